// File: rtl/sme_multi_if.sv
// Character-stream input and match-result bundle for sme_multi.
interface sme_multi_if #(
  parameter int unsigned STR_MAX = 32
);
  localparam int unsigned IW = $clog2(STR_MAX);
  localparam int unsigned CW = $clog2(STR_MAX + 1);

  logic [7:0]    chardata;
  logic          isstring;
  logic          ispattern;
  logic          nocase;
  logic          valid;
  logic          match;
  logic [IW-1:0] match_index;
  logic [CW-1:0] match_count;

  modport master (
    output chardata, isstring, ispattern, nocase,
    input  valid, match, match_index, match_count
  );

  modport slave (
    input  chardata, isstring, ispattern, nocase,
    output valid, match, match_index, match_count
  );
endinterface

// File: rtl/sme_multi.sv
// String-matching engine: stores one string, matches streamed patterns with
// '.' wildcard, '^'/'$' word anchors and optional case folding.
module sme_multi #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8
) (
  input logic        clk,
  input logic        reset,
  sme_multi_if.slave bus
);
  localparam int unsigned IW  = $clog2(STR_MAX);
  localparam int unsigned CW  = $clog2(STR_MAX + 1);
  localparam int unsigned PW  = $clog2(PAT_MAX + 1);
  localparam int unsigned PIW = $clog2(PAT_MAX);
  localparam logic [7:0]  SPACE = 8'h20;

  typedef enum logic [2:0] {IDLE, RD_STR, RD_PAT, SCAN, OUT} state_t;

  state_t        state;
  logic [7:0]    str_mem [STR_MAX];
  logic [7:0]    pat_mem [PAT_MAX];
  logic [CW-1:0] n_len;
  logic [CW-1:0] s_idx;
  logic [CW-1:0] cnt_acc;
  logic [PW-1:0] m_len;
  logic [IW-1:0] idx_acc;
  logic          nocase_r;
  logic          prev_str;
  logic          found;

  function automatic logic [7:0] fold(input logic [7:0] c, input logic en);
    return (en && c >= "A" && c <= "Z") ? c + 8'h20 : c;
  endfunction

  int         n_i, m_i, l_i, s_i, h_i, last_i, mi1;
  logic       head_c, tail_c, cand_c, last_c, hit_c;
  logic [7:0] pc, sc;

  // Evaluate candidate start s_idx against the core pattern in one cycle.
  always_comb begin
    n_i    = int'(n_len);
    m_i    = int'(m_len);
    s_i    = int'(s_idx);
    mi1    = (m_i > 0) ? m_i - 1 : 0;
    pc     = 8'h00;
    sc     = 8'h00;
    head_c = (m_i >= 1) && (pat_mem[0] == "^");
    tail_c = (m_i >= 1) && (pat_mem[PIW'(mi1)] == "$");
    h_i    = head_c ? 1 : 0;
    l_i    = m_i - h_i - (tail_c ? 1 : 0);
    cand_c = (l_i > 0) && (l_i <= n_i);
    last_i = cand_c ? n_i - l_i : 0;
    last_c = (s_i >= last_i);
    hit_c  = cand_c;
    for (int k = 0; k < int'(PAT_MAX); k++) begin
      if (k < l_i) begin
        pc = pat_mem[PIW'(k + h_i)];
        sc = (s_i + k < int'(STR_MAX)) ? str_mem[IW'(s_i + k)] : 8'h00;
        if (pc != "." && fold(sc, nocase_r) != fold(pc, nocase_r)) hit_c = 1'b0;
      end
    end
    if (head_c && s_i != 0 && str_mem[IW'(s_i - 1)] != SPACE) hit_c = 1'b0;
    if (tail_c && (s_i + l_i) != n_i &&
        ((s_i + l_i) >= int'(STR_MAX) || str_mem[IW'(s_i + l_i)] != SPACE)) hit_c = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      n_len           <= '0;
      m_len           <= '0;
      s_idx           <= '0;
      cnt_acc         <= '0;
      idx_acc         <= '0;
      found           <= 1'b0;
      nocase_r        <= 1'b0;
      prev_str        <= 1'b0;
      bus.valid       <= 1'b0;
      bus.match       <= 1'b0;
      bus.match_index <= '0;
      bus.match_count <= '0;
      for (int i = 0; i < int'(STR_MAX); i++) str_mem[i] <= 8'h00;
      for (int i = 0; i < int'(PAT_MAX); i++) pat_mem[i] <= 8'h00;
    end else begin
      prev_str        <= bus.isstring && !bus.ispattern;
      bus.valid       <= 1'b0;
      bus.match       <= 1'b0;
      bus.match_index <= '0;
      bus.match_count <= '0;
      case (state)
        IDLE, OUT, RD_STR: begin
          if (bus.ispattern) begin
            state      <= RD_PAT;
            pat_mem[0] <= bus.chardata;
            m_len      <= PW'(1);
            nocase_r   <= bus.nocase;
            s_idx      <= '0;
          end else if (bus.isstring) begin
            state <= RD_STR;
            // A gap in isstring (or a fresh dispatch) starts a new string.
            if (state != RD_STR || !prev_str) begin
              str_mem[0] <= bus.chardata;
              n_len      <= CW'(1);
            end else if (n_len < CW'(STR_MAX)) begin
              str_mem[IW'(n_len)] <= bus.chardata;
              n_len               <= n_len + 1'b1;
            end
          end else if (state != RD_STR) begin
            state <= IDLE;
          end
        end
        RD_PAT: begin
          if (bus.ispattern) begin
            if (m_len < PW'(PAT_MAX)) begin
              pat_mem[PIW'(m_len)] <= bus.chardata;
              m_len                <= m_len + 1'b1;
            end
          end else begin
            // First cycle without ispattern already evaluates candidate 0.
            cnt_acc <= CW'(hit_c);
            found   <= hit_c;
            idx_acc <= '0;
            if (last_c) begin
              state           <= OUT;
              bus.valid       <= 1'b1;
              bus.match       <= hit_c;
              bus.match_count <= CW'(hit_c);
            end else begin
              state <= SCAN;
              s_idx <= s_idx + 1'b1;
            end
          end
        end
        SCAN: begin
          cnt_acc <= cnt_acc + CW'(hit_c);
          found   <= found | hit_c;
          if (hit_c && !found) idx_acc <= IW'(s_idx);
          if (last_c) begin
            state           <= OUT;
            bus.valid       <= 1'b1;
            bus.match       <= found | hit_c;
            bus.match_index <= found ? idx_acc : (hit_c ? IW'(s_idx) : '0);
            bus.match_count <= cnt_acc + CW'(hit_c);
          end else begin
            s_idx <= s_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_multi.sv
// Bench for sme_multi: vector table plus hand sequences, scoreboard-checked results.
module tb_sme_multi;
  logic clk;
  logic reset;

  sme_multi_if #(.STR_MAX(32)) bus ();

  sme_multi #(.STR_MAX(32), .PAT_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string s;
    string p;
    bit    nc;
    bit    m;
    int    idx;
    int    cnt;
    int    lat;
  } vec_t;

  typedef struct {
    string name;
    bit    m;
    int    idx;
    int    cnt;
    int    lat;
    int    start;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;
  int   cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: pop on each valid, otherwise outputs must stay zero.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, ".match"}, int'(bus.match), int'(e.m));
          chk({e.name, ".index"}, int'(bus.match_index), e.idx);
          chk({e.name, ".count"}, int'(bus.match_count), e.cnt);
          chk({e.name, ".latency"}, cyc - e.start, e.lat);
        end
      end else begin
        total++;
        if (bus.match || bus.match_index != 0 || bus.match_count != 0) begin
          bad++;
          $display("FAIL idle_outputs m=%0d i=%0d c=%0d required 0", bus.match,
                   bus.match_index, bus.match_count);
        end
      end
    end
  end

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      bus.chardata  = s[i];
      bus.isstring  = 1'b1;
      bus.ispattern = 1'b0;
    end
  endtask

  task automatic send_pat(input string p, input bit nc, input bit m, input int idx,
                          input int cnt, input int lat);
    exp_t e;
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk);
      bus.chardata  = p[i];
      bus.isstring  = 1'b0;
      bus.ispattern = 1'b1;
      bus.nocase    = nc;
    end
    @(negedge clk);
    bus.chardata  = 8'h00;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    bus.nocase    = 1'b0;
    e.name  = p;
    e.m     = m;
    e.idx   = idx;
    e.cnt   = cnt;
    e.lat   = lat;
    e.start = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  vec_t  vt[$];
  string a33;
  string a32;

  initial begin
    reset         = 1'b1;
    bus.chardata  = 8'h00;
    bus.isstring  = 1'b0;
    bus.ispattern = 1'b0;
    bus.nocase    = 1'b0;
    a33 = "";
    for (int i = 0; i < 33; i++) a33 = {a33, "a"};
    a32 = a33.substr(0, 31);

    vt.push_back('{"hello world", "o",        1'b0, 1'b1, 4,  2,  11});
    vt.push_back('{"",            "^wor",     1'b0, 1'b1, 6,  1,  9});
    vt.push_back('{"",            "^orl",     1'b0, 1'b0, 0,  0,  9});
    vt.push_back('{"",            "ld$",      1'b0, 1'b1, 9,  1,  10});
    vt.push_back('{"",            "d$",       1'b0, 1'b1, 10, 1,  11});
    vt.push_back('{"",            "^hello$",  1'b0, 1'b1, 0,  1,  7});
    vt.push_back('{"",            "^$",       1'b0, 1'b0, 0,  0,  1});
    vt.push_back('{"",            "w.r",      1'b1, 1'b1, 6,  1,  9});
    vt.push_back('{"Hello",       "h.L",      1'b1, 1'b1, 0,  1,  3});
    vt.push_back('{"",            "h.L",      1'b0, 1'b0, 0,  0,  3});
    vt.push_back('{"",            "l.l",      1'b0, 1'b0, 0,  0,  3});
    vt.push_back('{a33,           "aaaaaaaa", 1'b0, 1'b1, 0,  25, 25});
    vt.push_back('{"",            "aaaaaaaaaa", 1'b0, 1'b1, 0, 25, 25});
    vt.push_back('{"",            "a.",       1'b0, 1'b1, 0,  31, 31});

    repeat (3) @(negedge clk);
    chk("reset.valid", int'(bus.valid), 0);
    chk("reset.match", int'(bus.match), 0);
    chk("reset.index", int'(bus.match_index), 0);
    chk("reset.count", int'(bus.match_count), 0);
    reset = 1'b0;

    foreach (vt[i]) begin
      if (vt[i].s.len() != 0) send_str(vt[i].s);
      send_pat(vt[i].p, vt[i].nc, vt[i].m, vt[i].idx, vt[i].cnt, vt[i].lat);
      drain();
    end

    // Too-long pattern, then a new pattern dispatched in the valid cycle.
    send_str("ab");
    send_pat("abc", 1'b0, 1'b0, 0, 0, 1);
    send_pat("b", 1'b0, 1'b1, 1, 1, 2);
    drain();

    // Reset in the middle of a long scan suppresses valid.
    send_str(a32);
    send_pat("a", 1'b0, 1'b1, 0, 32, 32);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midreset.valid", int'(bus.valid), 0);
    chk("midreset.match", int'(bus.match), 0);
    chk("midreset.count", int'(bus.match_count), 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    send_str("xyz");
    send_pat("z", 1'b0, 1'b1, 2, 1, 3);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
